cg_rvarch_instr_encoder: RTL
============================

# cg_rvarch_instr_encoder

Streaming RV32I instruction encoder: packs operand fields and an architectural immediate into a 32-bit instruction word, and is the inverse of the format-specific immediate extraction used in decode. Used by test generators, boot-ROM/patch builders and self-modifying-code support logic. Behind a ready/valid input port it has a 2-entry elastic buffer: one output register plus one skid register. It flags immediates that are not representable in the chosen format and counts erroneous transactions.

## Interface
- INSTR_WIDTH, 32, instruction width; only 32 is supported.
- DATA_WIDTH, 32, width of i_imm; 32 or 64.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

- i_clk  input  1  clock
- i_rst_n  input  1  reset; asynchronous, active-low
- i_valid  input  1  input transaction valid
- o_ready  output  1  encoder can accept (registered)
- i_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
- i_opcode  input  7  opcode field
- i_rd, i_rs1, i_rs2  input  5 each  register fields
- i_funct3  input  3  funct3 field
- i_funct7  input  7  funct7 field (R only)
- i_imm  input  DATA_WIDTH  immediate as a signed byte value/offset (U: full value with low 12 bits zero)
- o_valid  output  1  output word valid
- i_ready  input  1  downstream accepts
- o_instr  output  INSTR_WIDTH  encoded instruction
- o_imm_err  output  1  immediate not representable; qualifies o_instr
- o_fmt_err  output  1  illegal i_fmt; qualifies o_instr
- o_err_count  output  ERR_CNT_WIDTH  saturating count of accepted erroneous transactions

## Operation
- Input acceptance is `i_valid && o_ready`. Output handoff is `o_valid && i_ready`.
- Encoding (MSB→LSB; opcode always in bits [6:0]):
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode
  - I: imm[11:0] | rs1 | funct3 | rd | opcode
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode
  - U: imm[31:12] | rd | opcode
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode
  - Fields unused by a format are ignored.
- Representability checks (o_imm_err=1 on failure):
  - I/S: imm[DATA_WIDTH-1:11] are all equal.
  - B: imm[DATA_WIDTH-1:12] are all equal, and imm[0]=0.
  - J: imm[DATA_WIDTH-1:20] are all equal, and imm[0]=0.
  - U: imm[11:0]=0, and imm[DATA_WIDTH-1:31] are all equal.
  - R: never fails.
- On an immediate error the word is still emitted with truncated fields.
- Illegal format: o_instr=0, o_fmt_err=1, o_imm_err=0 (format error dominates).
- Error flags are registered together with o_instr and move through the buffer with it.
- o_err_count increments by 1 on the acceptance cycle of any transaction with either error. It saturates at 2^ERR_CNT_WIDTH-1 and is never cleared except by reset.
- Buffer behaviour:
  - The output register loads from skid if skid is full; otherwise it loads from input when the output register is empty or being handed off.
  - Skid captures input only when input is accepted, the output register is full, and there is no handoff that cycle.
  - o_ready = !skid_full, registered.
  - Order is preserved; no drops, no duplicates.

## Timing
- Reset (async assert, sync deassert expected):
  - o_valid=0, o_instr=0, o_imm_err=0, o_fmt_err=0, o_err_count=0, o_ready=0.
  - o_ready rises on the first i_clk edge after deassertion.
  - Reset mid-operation discards both buffered entries immediately.
- Latency: 1 cycle from acceptance to o_valid when the buffer is empty.
- Throughput: 1 transaction/cycle while i_ready=1.
- o_instr and the error flags are stable while `o_valid && !i_ready`.
- Simultaneous accept and handoff with skid empty: the output register reloads from input; skid stays empty.
- Handoff with skid full: skid moves to the output register; o_ready returns to 1 the next cycle.
- Both entries full: o_ready=0; i_valid is ignored.
- Counter at saturation with an erroneous accept: holds its value.

## Test plan
- I-type, fmt=1, opcode=0x13, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF -> o_instr=0xFFF10093 one cycle after accept; no errors.
- S-type, fmt=2, opcode=0x23, rs1=2, rs2=5, funct3=2, imm=8 -> 0x00512423. J-type, fmt=5, opcode=0x6F, rd=1, imm=0x800 -> 0x001000EF.
- Errors:
  - B with imm=0x5 -> o_imm_err=1, o_err_count 0->1.
  - I with imm=0x800 -> o_imm_err=1, count 2.
  - fmt=7 -> o_instr=0, o_fmt_err=1, count 3.
  - R with any imm -> no error.
- Backpressure: hold i_ready=0 and offer 3 back-to-back words A,B,C -> A in output, B in skid, o_ready=0, C stalls. Raise i_ready -> A,B,C delivered in order, one per cycle.
- Saturation: ERR_CNT_WIDTH=2 with 5 erroneous transactions -> o_err_count=3.
- Assert i_rst_n=0 with both entries full -> o_valid=0 and count=0 immediately. After release, o_ready=1 after one edge and the next word encodes correctly.

Source files
------------

// File: rtl/cg_rvarch_instr_encoder_if.sv
// Streaming port bundle for the RV32I instruction encoder.
// The producer/consumer side uses the master modport; the encoder uses slave.
interface cg_rvarch_instr_encoder_if #(
    parameter int INSTR_WIDTH   = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
);
    logic                     i_valid;
    logic                     o_ready;
    logic [2:0]               i_fmt;
    logic [6:0]               i_opcode;
    logic [4:0]               i_rd;
    logic [4:0]               i_rs1;
    logic [4:0]               i_rs2;
    logic [2:0]               i_funct3;
    logic [6:0]               i_funct7;
    logic [DATA_WIDTH-1:0]    i_imm;
    logic                     o_valid;
    logic                     i_ready;
    logic [INSTR_WIDTH-1:0]   o_instr;
    logic                     o_imm_err;
    logic                     o_fmt_err;
    logic [ERR_CNT_WIDTH-1:0] o_err_count;

    modport master (
        output i_valid, i_fmt, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_ready,
        input  o_ready, o_valid, o_instr, o_imm_err, o_fmt_err, o_err_count
    );

    modport slave (
        input  i_valid, i_fmt, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_ready,
        output o_ready, o_valid, o_instr, o_imm_err, o_fmt_err, o_err_count
    );
endinterface

// File: rtl/cg_rvarch_instr_encoder.sv
// RV32I instruction encoder: packs fields + immediate into a 32-bit word behind a
// two-entry elastic buffer (output register + skid), with representability checks.
module cg_rvarch_instr_encoder #(
    parameter int INSTR_WIDTH   = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    cg_rvarch_instr_encoder_if.slave bus
);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] imm;
    logic [6:0]            op;
    logic [4:0]            rd, rs1, rs2;
    logic [2:0]            f3;

    assign imm = bus.i_imm;
    assign op  = bus.i_opcode;
    assign rd  = bus.i_rd;
    assign rs1 = bus.i_rs1;
    assign rs2 = bus.i_rs2;
    assign f3  = bus.i_funct3;

    // An immediate fits when every bit from the format's sign position up is equal.
    logic fits_11, fits_12, fits_20, fits_31;
    assign fits_11 = (&imm[DATA_WIDTH-1:11]) | ~(|imm[DATA_WIDTH-1:11]);
    assign fits_12 = (&imm[DATA_WIDTH-1:12]) | ~(|imm[DATA_WIDTH-1:12]);
    assign fits_20 = (&imm[DATA_WIDTH-1:20]) | ~(|imm[DATA_WIDTH-1:20]);
    assign fits_31 = (&imm[DATA_WIDTH-1:31]) | ~(|imm[DATA_WIDTH-1:31]);

    logic [INSTR_WIDTH-1:0] enc_instr;
    logic                   enc_imm_err;
    logic                   enc_fmt_err;

    always_comb begin
        enc_instr   = '0;
        enc_imm_err = 1'b0;
        enc_fmt_err = 1'b0;
        case (bus.i_fmt)
            3'd0: enc_instr = {bus.i_funct7, rs2, rs1, f3, rd, op};
            3'd1: begin
                enc_instr   = {imm[11:0], rs1, f3, rd, op};
                enc_imm_err = ~fits_11;
            end
            3'd2: begin
                enc_instr   = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                enc_imm_err = ~fits_11;
            end
            3'd3: begin
                enc_instr   = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                enc_imm_err = ~fits_12 | imm[0];
            end
            3'd4: begin
                enc_instr   = {imm[31:12], rd, op};
                enc_imm_err = (|imm[11:0]) | ~fits_31;
            end
            3'd5: begin
                enc_instr   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                enc_imm_err = ~fits_20 | imm[0];
            end
            default: enc_fmt_err = 1'b1;
        endcase
    end

    logic                     out_valid_q, out_valid_d;
    logic [INSTR_WIDTH-1:0]   out_instr_q, out_instr_d;
    logic                     out_imm_err_q, out_imm_err_d;
    logic                     out_fmt_err_q, out_fmt_err_d;
    logic                     skid_valid_q, skid_valid_d;
    logic [INSTR_WIDTH-1:0]   skid_instr_q, skid_instr_d;
    logic                     skid_imm_err_q, skid_imm_err_d;
    logic                     skid_fmt_err_q, skid_fmt_err_d;
    logic                     ready_q, ready_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic accept, handoff;
    assign accept  = bus.i_valid & ready_q;
    assign handoff = out_valid_q & bus.i_ready;

    always_comb begin
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_imm_err_d  = out_imm_err_q;
        out_fmt_err_d  = out_fmt_err_q;
        skid_valid_d   = skid_valid_q;
        skid_instr_d   = skid_instr_q;
        skid_imm_err_d = skid_imm_err_q;
        skid_fmt_err_d = skid_fmt_err_q;
        err_cnt_d      = err_cnt_q;

        if (handoff || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_d   = 1'b1;
                out_instr_d   = skid_instr_q;
                out_imm_err_d = skid_imm_err_q;
                out_fmt_err_d = skid_fmt_err_q;
                skid_valid_d  = 1'b0;
            end else if (accept) begin
                out_valid_d   = 1'b1;
                out_instr_d   = enc_instr;
                out_imm_err_d = enc_imm_err;
                out_fmt_err_d = enc_fmt_err;
            end else begin
                out_valid_d   = 1'b0;
            end
        end else if (accept) begin
            // Output register is stalled; park the new word in the skid slot.
            skid_valid_d   = 1'b1;
            skid_instr_d   = enc_instr;
            skid_imm_err_d = enc_imm_err;
            skid_fmt_err_d = enc_fmt_err;
        end

        ready_d = ~skid_valid_d;

        if (accept && (enc_imm_err || enc_fmt_err) && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_q    <= 1'b0;
            out_instr_q    <= '0;
            out_imm_err_q  <= 1'b0;
            out_fmt_err_q  <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_instr_q   <= '0;
            skid_imm_err_q <= 1'b0;
            skid_fmt_err_q <= 1'b0;
            ready_q        <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_imm_err_q  <= out_imm_err_d;
            out_fmt_err_q  <= out_fmt_err_d;
            skid_valid_q   <= skid_valid_d;
            skid_instr_q   <= skid_instr_d;
            skid_imm_err_q <= skid_imm_err_d;
            skid_fmt_err_q <= skid_fmt_err_d;
            ready_q        <= ready_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign bus.o_valid     = out_valid_q;
    assign bus.o_instr     = out_instr_q;
    assign bus.o_imm_err   = out_imm_err_q;
    assign bus.o_fmt_err   = out_fmt_err_q;
    assign bus.o_ready     = ready_q;
    assign bus.o_err_count = err_cnt_q;
endmodule
